// File: rtl/wash_cycle_scheduler.sv
// wash_cycle_scheduler: program sequencer driving automatic_washing_machine.
// Optional WASH_DOOR_PAUSE_EN: an open door pauses RUN/SPIN tick counting.
module wash_cycle_scheduler #(
    parameter int CW          = 8,
    parameter int WASH_TICKS  = 16,
    parameter int RINSE_TICKS = 8,
    parameter int SPIN_TICKS  = 12,
    parameter int WD_LIMIT    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_start,
    input  logic       prog_abort,
    input  logic [1:0] rinse_count,
    input  logic       door_close,
    input  logic       door_lock,
    input  logic       motor_on,
    input  logic       fill_value_on,
    input  logic       drain_value_on,
    input  logic       done,
    output logic       start,
    output logic       detergent_added,
    output logic       cycle_timeout,
    output logic       spin_timeout,
    output logic       busy,
    output logic       fault,
    output logic       prog_done,
    output logic [2:0] phase,
    output logic [1:0] rinse_left
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_FILL   = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_SPIN   = 3'd5,
        S_FINISH = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam int WW = $clog2(WD_LIMIT + 1);
    localparam logic [CW-1:0] WASH_LAST  = CW'(WASH_TICKS - 1);
    localparam logic [CW-1:0] RINSE_LAST = CW'(RINSE_TICKS - 1);
    localparam logic [CW-1:0] SPIN_LAST  = CW'(SPIN_TICKS - 1);
    localparam logic [CW-1:0] TICK_MAX   = '1;
    localparam logic [WW-1:0] WD_LAST    = WW'(WD_LIMIT - 1);
    localparam logic [WW-1:0] WD_MAX     = '1;

    state_t        state_q, state_d;
    logic [CW-1:0] tick_q;
    logic [WW-1:0] wd_q;
    logic [1:0]    rinse_q, rinse_d;
    logic          pass_q, pass_d;
    logic          gap_q, gap_d;
    logic          fill_prev_q;
    logic          start_q, start_d;
    logic          det_q, det_d;
    logic          ct_q, ct_d;
    logic          st_q, st_d;
    logic          pd_q, pd_d;
    logic          tick_inc, wd_inc, go_fault;
    logic          door_ok;
    logic [CW-1:0] run_last;

`ifdef WASH_DOOR_PAUSE_EN
    assign door_ok = door_close;
`else
    assign door_ok = 1'b1;
`endif

    assign run_last = pass_q ? RINSE_LAST : WASH_LAST;

    always_comb begin
        state_d  = state_q;
        rinse_d  = rinse_q;
        pass_d   = pass_q;
        gap_d    = gap_q;
        start_d  = start_q;
        det_d    = det_q;
        ct_d     = ct_q;
        st_d     = st_q;
        pd_d     = 1'b0;
        tick_inc = 1'b0;
        wd_inc   = 1'b0;
        go_fault = 1'b0;
        if (prog_abort) begin
            state_d = S_IDLE;
            rinse_d = 2'd0;
            pass_d  = 1'b0;
            gap_d   = 1'b0;
            start_d = 1'b0;
            det_d   = 1'b0;
            ct_d    = 1'b0;
            st_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (prog_start && door_close) begin
                        state_d = S_START;
                        rinse_d = rinse_count;
                        pass_d  = 1'b0;
                        start_d = 1'b1;
                    end
                end
                S_START: begin
                    if (door_lock) state_d = S_FILL;
                end
                S_FILL: begin
                    if (fill_prev_q && !fill_value_on) begin
                        det_d   = 1'b1;
                        state_d = S_RUN;
                    end else if (fill_value_on) begin
                        wd_inc = 1'b1;
                        if (wd_q == WD_LAST) go_fault = 1'b1;
                    end
                end
                S_RUN: begin
                    if (motor_on && !drain_value_on && door_ok) begin
                        tick_inc = 1'b1;
                        if (tick_q == run_last) begin
                            ct_d    = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_value_on) begin
                        ct_d    = 1'b0;
                        state_d = S_SPIN;
                    end else begin
                        wd_inc = 1'b1;
                        if (wd_q == WD_LAST) go_fault = 1'b1;
                    end
                end
                S_SPIN: begin
                    if (motor_on && door_ok) begin
                        tick_inc = 1'b1;
                        if (tick_q == SPIN_LAST) begin
                            st_d    = 1'b1;
                            state_d = S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    // gap cycle keeps FINISH but shows idle drives before relaunch
                    if (gap_q) begin
                        gap_d   = 1'b0;
                        start_d = 1'b1;
                        state_d = S_START;
                    end else if (done) begin
                        st_d    = 1'b0;
                        det_d   = 1'b0;
                        start_d = 1'b0;
                        if (rinse_q != 2'd0) begin
                            rinse_d = rinse_q - 2'd1;
                            pass_d  = 1'b1;
                            gap_d   = 1'b1;
                        end else begin
                            pd_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_FAULT: ;
                default: state_d = S_IDLE;
            endcase
            if (go_fault) begin
                state_d = S_FAULT;
                start_d = 1'b0;
                det_d   = 1'b0;
                ct_d    = 1'b0;
                st_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            wd_q        <= '0;
            rinse_q     <= 2'd0;
            pass_q      <= 1'b0;
            gap_q       <= 1'b0;
            fill_prev_q <= 1'b0;
            start_q     <= 1'b0;
            det_q       <= 1'b0;
            ct_q        <= 1'b0;
            st_q        <= 1'b0;
            pd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rinse_q     <= rinse_d;
            pass_q      <= pass_d;
            gap_q       <= gap_d;
            fill_prev_q <= fill_value_on;
            start_q     <= start_d;
            det_q       <= det_d;
            ct_q        <= ct_d;
            st_q        <= st_d;
            pd_q        <= pd_d;
            if (state_d != state_q)
                tick_q <= '0;
            else if (tick_inc && tick_q != TICK_MAX)
                tick_q <= tick_q + CW'(1);
            if (state_d != state_q)
                wd_q <= '0;
            else if (wd_inc && wd_q != WD_MAX)
                wd_q <= wd_q + WW'(1);
        end
    end

    assign start           = start_q;
    assign detergent_added = det_q;
    assign cycle_timeout   = ct_q;
    assign spin_timeout    = st_q;
    assign prog_done       = pd_q;
    assign phase           = state_q;
    assign rinse_left      = rinse_q;
    assign busy            = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign fault           = (state_q == S_FAULT);

endmodule

// File: tb/tb_wash_cycle_scheduler.sv
// tb_wash_cycle_scheduler: directed bench with a simple washing-machine model.
// Define WASH_DOOR_PAUSE_EN to also cover the door-pause behaviour.
module tb_wash_cycle_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       prog_start, prog_abort;
    logic [1:0] rinse_count;
    logic       door_close, door_lock, motor_on;
    logic       fill_value_on, drain_value_on, done;
    logic       start, detergent_added, cycle_timeout, spin_timeout;
    logic       busy, fault, prog_done;
    logic [2:0] phase;
    logic [1:0] rinse_left;

    int tests = 0;
    int fails = 0;

    bit mdl_en;
    int ms, fc;
    int run_cnt, run_ph, spin_cnt, wd_cnt, pd_cnt, gap_cnt, ct_hits;

    always #5 clk = ~clk;

    wash_cycle_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .prog_start     (prog_start),
        .prog_abort     (prog_abort),
        .rinse_count    (rinse_count),
        .door_close     (door_close),
        .door_lock      (door_lock),
        .motor_on       (motor_on),
        .fill_value_on  (fill_value_on),
        .drain_value_on (drain_value_on),
        .done           (done),
        .start          (start),
        .detergent_added(detergent_added),
        .cycle_timeout  (cycle_timeout),
        .spin_timeout   (spin_timeout),
        .busy           (busy),
        .fault          (fault),
        .prog_done      (prog_done),
        .phase          (phase),
        .rinse_left     (rinse_left)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mach_idle();
        door_lock      = 1'b0;
        fill_value_on  = 1'b0;
        motor_on       = 1'b0;
        drain_value_on = 1'b0;
        done           = 1'b0;
    endtask

    task automatic clr_cnt();
        run_cnt = 0; run_ph = 0; spin_cnt = 0; wd_cnt = 0;
        pd_cnt = 0; gap_cnt = 0; ct_hits = 0;
    endtask

    // One cycle: machine model reacts, then counters note what the next edge sees
    task automatic cyc();
        @(negedge clk);
        if (mdl_en) begin
            if (!start) begin
                ms = 0;
                mach_idle();
            end
            case (ms)
                0: if (start) begin
                    door_lock = 1'b1; fill_value_on = 1'b1; fc = 0; ms = 1;
                end
                1: begin
                    fc++;
                    if (fc == 3) begin
                        fill_value_on = 1'b0; motor_on = 1'b1; ms = 2;
                    end
                end
                2: if (cycle_timeout) begin
                    motor_on = 1'b0; drain_value_on = 1'b1; ms = 3;
                end
                3: if (!cycle_timeout) begin
                    motor_on = 1'b1; ms = 4;
                end
                4: if (spin_timeout) begin
                    motor_on = 1'b0; drain_value_on = 1'b0; done = 1'b1; ms = 5;
                end
                default: ;
            endcase
        end
        if (phase == 3'd3 && motor_on && !drain_value_on) run_cnt++;
        if (phase == 3'd3) run_ph++;
        if (phase == 3'd5 && motor_on) spin_cnt++;
        if (phase == 3'd2 && fill_value_on) wd_cnt++;
        if (prog_done) pd_cnt++;
        if (busy && !start) gap_cnt++;
        if (cycle_timeout) ct_hits++;
    endtask

    task automatic launch(input logic [1:0] rc);
        rinse_count = rc;
        prog_start  = 1'b1;
        cyc();
        prog_start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (phase != 3'd0 && k < 400) begin cyc(); k++; end
        check({tag, "_idle"}, phase, 3'd0);
    endtask

    initial begin
        int k;
        int exp_run [3] = '{16, 8, 8};
        int exp_rl  [3] = '{2, 1, 0};
        reset = 1'b0; prog_start = 1'b0; prog_abort = 1'b0;
        rinse_count = 2'd0; door_close = 1'b1; mdl_en = 1'b0;
        mach_idle();
        clr_cnt();
        cyc(); cyc();
        check("rst_phase", phase, 3'd0);
        check("rst_start", start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_pdone", prog_done, 1'b0);
        check("rst_rinse", rinse_left, 2'd0);
        reset = 1'b1;
        cyc();

        // single wash pass
        mdl_en = 1'b1;
        clr_cnt();
        launch(2'd0);
        check("A_start_rise", start, 1'b1);
        check("A_phase_start", phase, 3'd1);
        k = 0;
        while (!cycle_timeout && k < 300) begin cyc(); k++; end
        check("A_ct_seen", cycle_timeout, 1'b1);
        check("A_run_ticks", run_cnt, 16);
        check("A_run_phase", run_ph, 16);
        check("A_det", detergent_added, 1'b1);
        k = 0;
        while (!spin_timeout && k < 300) begin cyc(); k++; end
        check("A_st_seen", spin_timeout, 1'b1);
        check("A_spin_ticks", spin_cnt, 12);
        check("A_ct_low", cycle_timeout, 1'b0);
        wait_idle("A");
        cyc(); cyc();
        check("A_pdone_once", pd_cnt, 1);
        check("A_busy_end", busy, 1'b0);
        check("A_det_end", detergent_added, 1'b0);
        check("A_start_end", start, 1'b0);

        // wash plus two rinses
        clr_cnt();
        launch(2'd2);
        for (int p = 0; p < 3; p++) begin
            k = 0;
            while (!cycle_timeout && k < 300) begin cyc(); k++; end
            check($sformatf("B_ct%0d", p), cycle_timeout, 1'b1);
            check($sformatf("B_run%0d", p), run_cnt, exp_run[p]);
            check($sformatf("B_rl%0d", p), rinse_left, exp_rl[p]);
            run_cnt = 0;
            k = 0;
            while (cycle_timeout && k < 100) begin cyc(); k++; end
        end
        wait_idle("B");
        cyc();
        check("B_pdone_once", pd_cnt, 1);
        check("B_start_gaps", gap_cnt, 2);

        // fill watchdog
        mdl_en = 1'b0;
        mach_idle();
        clr_cnt();
        launch(2'd0);
        check("C_phase_start", phase, 3'd1);
        door_lock = 1'b1;
        fill_value_on = 1'b1;
        k = 0;
        while (phase != 3'd7 && k < 100) begin cyc(); k++; end
        check("C_wd_cycles", wd_cnt, 32);
        check("C_fault", fault, 1'b1);
        check("C_phase_fault", phase, 3'd7);
        check("C_drives", {start, detergent_added, cycle_timeout, spin_timeout}, 4'b0);
        check("C_busy", busy, 1'b0);
        repeat (6) cyc();
        check("C_fault_hold", phase, 3'd7);
        prog_abort = 1'b1;
        cyc();
        prog_abort = 1'b0;
        check("C_abort_phase", phase, 3'd0);
        check("C_abort_fault", fault, 1'b0);
        mach_idle();

        // abort coincident with RUN terminal count
        mdl_en = 1'b1;
        clr_cnt();
        launch(2'd0);
        k = 0;
        while (!(phase == 3'd3 && run_cnt == 16) && k < 300) begin cyc(); k++; end
        check("D_reach_term", run_cnt, 16);
        prog_abort = 1'b1;
        cyc();
        prog_abort = 1'b0;
        check("D_phase", phase, 3'd0);
        check("D_start", start, 1'b0);
        repeat (20) cyc();
        check("D_ct_never", ct_hits, 0);

        // asynchronous reset in SPIN
        clr_cnt();
        launch(2'd1);
        k = 0;
        while (phase != 3'd5 && k < 300) begin cyc(); k++; end
        repeat (4) cyc();
        check("E_in_spin", phase, 3'd5);
        #2 reset = 1'b0;
        mdl_en = 1'b0;
        mach_idle();
        #1;
        check("E_outs", {start, detergent_added, cycle_timeout, spin_timeout,
                         busy, fault, prog_done}, 7'b0);
        check("E_phase", phase, 3'd0);
        check("E_rinse", rinse_left, 2'd0);
        cyc();
        reset = 1'b1;
        door_close = 1'b0;
        prog_start = 1'b1;
        cyc(); cyc();
        prog_start = 1'b0;
        check("E_ignore_phase", phase, 3'd0);
        check("E_ignore_start", start, 1'b0);
        door_close = 1'b1;

`ifdef WASH_DOOR_PAUSE_EN
        // door open five cycles mid-RUN
        mdl_en = 1'b1;
        clr_cnt();
        launch(2'd0);
        k = 0;
        while (!(phase == 3'd3 && run_cnt == 5) && k < 300) begin cyc(); k++; end
        door_close = 1'b0;
        repeat (5) cyc();
        door_close = 1'b1;
        k = 0;
        while (!cycle_timeout && k < 300) begin cyc(); k++; end
        check("F_ct_seen", cycle_timeout, 1'b1);
        check("F_run_phase", run_ph, 21);
        wait_idle("F");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
